id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of PC, operand and immediate fields.
REQ-002 Parameter CNTW, default 16, width of bubble statistics counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 IF_ID_valid  input  1  decode slot holds a real instruction.
REQ-006 IF_ID_pc, IF_ID_rd1, IF_ID_rd2, IF_ID_imm  input  XLEN each  decoded PC, register-file read data, immediate.
REQ-007 IF_ID_rs1, IF_ID_rs2, IF_ID_rd  input  5 each  decoded register indices.
REQ-008 IF_ID_uses_rs1, IF_ID_uses_rs2  input  1 each  instruction actually reads rs1/rs2.
REQ-009 IF_ID_RegWrite, IF_ID_MemRead, IF_ID_MemWrite, IF_ID_MemtoReg, IF_ID_ALUSrc, IF_ID_Branch  input  1 each  decode controls.
REQ-010 IF_ID_ALUOp  input  2, IF_ID_funct3  input  3, IF_ID_funct7_5  input  1  ALU decode fields.
REQ-011 flush  input  1  taken branch/jump resolved in EX; kill decode slot.
REQ-012 hold  input  1  downstream memory stall; freeze this register.
REQ-013 ID_EX_* outputs  output  same widths as REQ-005..REQ-010 (ID_EX_valid, ID_EX_pc, ID_EX_rd1, ID_EX_rd2, ID_EX_imm, ID_EX_rs1, ID_EX_rs2, ID_EX_rd, control fields)  registered EX-stage copy; rs1/rs2/rd feed the forwarding unit.
REQ-014 stall  output  1  combinational; freeze PC and IF/ID register this cycle.
REQ-015 bubble_count  output  CNTW  count of load-use bubbles inserted.

Function
REQ-016 load_use SHALL be combinational: ID_EX_valid & ID_EX_MemRead & (ID_EX_rd != 0) & IF_ID_valid & ((IF_ID_uses_rs1 & ID_EX_rd == IF_ID_rs1) | (IF_ID_uses_rs2 & ID_EX_rd == IF_ID_rs2)).
REQ-017 stall SHALL equal load_use & ~flush & ~hold.
REQ-018 Register update priority per rising edge SHALL be: flush > hold > load_use > capture.
REQ-019 flush: register loads a bubble regardless of hold or load_use.
REQ-020 hold (no flush): every ID_EX_* output keeps its value; bubble_count unchanged.
REQ-021 load_use (no flush, no hold): register loads a bubble; bubble_count increments.
REQ-022 capture: every ID_EX_* output takes its IF_ID_* input; latency exactly one cycle.
REQ-023 Bubble SHALL be: ID_EX_valid=0, all control bits 0, ALUOp/funct3/funct7_5=0, rs1/rs2/rd=0, pc/rd1/rd2/imm=0.
REQ-024 Captured instruction with IF_ID_valid=0 SHALL force RegWrite, MemRead, MemWrite, Branch outputs to 0.
REQ-025 bubble_count SHALL saturate at 2^CNTW-1; no wrap.
REQ-026 Flush bubbles SHALL NOT increment bubble_count.
REQ-027 Back-to-back dependent load after a bubble SHALL NOT re-stall (bubble has valid=0, rd=0).
REQ-028 Load with rd=x0 SHALL never cause a stall.

Reset
REQ-029 reset asserted: all ID_EX_* outputs 0, bubble_count 0, asynchronously, without a clock edge.
REQ-030 Consequently stall SHALL be 0 during and the cycle after reset release.
REQ-031 reset asserted mid-stall or mid-hold SHALL discard held contents; first edge after release performs normal priority evaluation.

Verification
REQ-032 Capture: IF_ID_valid=1, rd=5, rd1=0x1234, RegWrite=1, no flush/hold -> next edge ID_EX_rd=5, ID_EX_rd1=0x1234, ID_EX_RegWrite=1, stall=0.
REQ-033 Load-use: ID_EX holds lw x7 (MemRead=1, rd=7); IF_ID add x8,x7,x1 (uses_rs1=1) -> stall=1 that cycle; next edge ID_EX_valid=0, rd=0, bubble_count=1; following cycle stall=0, add captured.
REQ-034 False dependency: ID_EX lw x7; IF_ID rs2=7 with uses_rs2=0 -> stall=0, instruction captured; lw x0 with rs1=0 dependent -> stall=0.
REQ-035 Flush priority: load_use and flush both 1, hold=1 -> stall=0; next edge bubble loaded; bubble_count unchanged.
REQ-036 Hold: hold=1 for 3 cycles with changing IF_ID inputs -> ID_EX_* constant; hold released -> capture resumes next edge.
REQ-037 Saturation/reset: CNTW=2, force 5 load-use bubbles -> bubble_count=3; assert reset between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-side inputs and EX-stage outputs of the ID/EX pipeline register
interface id_ex_stage_if #(
    parameter int XLEN = 32,
    parameter int CNTW = 16
);
    // Decode slot (IF/ID side)
    logic            IF_ID_valid;
    logic [XLEN-1:0] IF_ID_pc;
    logic [XLEN-1:0] IF_ID_rd1;
    logic [XLEN-1:0] IF_ID_rd2;
    logic [XLEN-1:0] IF_ID_imm;
    logic [4:0]      IF_ID_rs1;
    logic [4:0]      IF_ID_rs2;
    logic [4:0]      IF_ID_rd;
    logic            IF_ID_uses_rs1;
    logic            IF_ID_uses_rs2;
    logic            IF_ID_RegWrite;
    logic            IF_ID_MemRead;
    logic            IF_ID_MemWrite;
    logic            IF_ID_MemtoReg;
    logic            IF_ID_ALUSrc;
    logic            IF_ID_Branch;
    logic [1:0]      IF_ID_ALUOp;
    logic [2:0]      IF_ID_funct3;
    logic            IF_ID_funct7_5;

    // Pipeline control from EX / memory stages
    logic            flush;
    logic            hold;

    // EX-stage copy
    logic            ID_EX_valid;
    logic [XLEN-1:0] ID_EX_pc;
    logic [XLEN-1:0] ID_EX_rd1;
    logic [XLEN-1:0] ID_EX_rd2;
    logic [XLEN-1:0] ID_EX_imm;
    logic [4:0]      ID_EX_rs1;
    logic [4:0]      ID_EX_rs2;
    logic [4:0]      ID_EX_rd;
    logic            ID_EX_RegWrite;
    logic            ID_EX_MemRead;
    logic            ID_EX_MemWrite;
    logic            ID_EX_MemtoReg;
    logic            ID_EX_ALUSrc;
    logic            ID_EX_Branch;
    logic [1:0]      ID_EX_ALUOp;
    logic [2:0]      ID_EX_funct3;
    logic            ID_EX_funct7_5;

    // Hazard status
    logic            stall;
    logic [CNTW-1:0] bubble_count;

    modport master (
        output IF_ID_valid, IF_ID_pc, IF_ID_rd1, IF_ID_rd2, IF_ID_imm,
               IF_ID_rs1, IF_ID_rs2, IF_ID_rd, IF_ID_uses_rs1, IF_ID_uses_rs2,
               IF_ID_RegWrite, IF_ID_MemRead, IF_ID_MemWrite, IF_ID_MemtoReg,
               IF_ID_ALUSrc, IF_ID_Branch, IF_ID_ALUOp, IF_ID_funct3, IF_ID_funct7_5,
               flush, hold,
        input  ID_EX_valid, ID_EX_pc, ID_EX_rd1, ID_EX_rd2, ID_EX_imm,
               ID_EX_rs1, ID_EX_rs2, ID_EX_rd,
               ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
               ID_EX_ALUSrc, ID_EX_Branch, ID_EX_ALUOp, ID_EX_funct3, ID_EX_funct7_5,
               stall, bubble_count
    );

    modport slave (
        input  IF_ID_valid, IF_ID_pc, IF_ID_rd1, IF_ID_rd2, IF_ID_imm,
               IF_ID_rs1, IF_ID_rs2, IF_ID_rd, IF_ID_uses_rs1, IF_ID_uses_rs2,
               IF_ID_RegWrite, IF_ID_MemRead, IF_ID_MemWrite, IF_ID_MemtoReg,
               IF_ID_ALUSrc, IF_ID_Branch, IF_ID_ALUOp, IF_ID_funct3, IF_ID_funct7_5,
               flush, hold,
        output ID_EX_valid, ID_EX_pc, ID_EX_rd1, ID_EX_rd2, ID_EX_imm,
               ID_EX_rs1, ID_EX_rs2, ID_EX_rd,
               ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
               ID_EX_ALUSrc, ID_EX_Branch, ID_EX_ALUOp, ID_EX_funct3, ID_EX_funct7_5,
               stall, bubble_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection and bubble counter
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int CNTW = 16
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);

    // One EX-stage slot; an all-zero value is the bubble (valid=0, no side effects).
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            alu_src;
        logic            branch;
        logic [1:0]      alu_op;
        logic [2:0]      funct3;
        logic            funct7_5;
    } ex_slot_t;

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    ex_slot_t        ex_q;
    ex_slot_t        capture;
    logic [CNTW-1:0] bubble_q;
    logic            rs1_hit;
    logic            rs2_hit;
    logic            load_use;

    // Load-use hazard: the load now in EX writes a register the decode slot really reads.
    // rd=x0 never hazards, and a bubble in EX (valid=0, rd=0) cannot re-stall.
    always_comb begin
        rs1_hit  = bus.IF_ID_uses_rs1 && (ex_q.rd == bus.IF_ID_rs1);
        rs2_hit  = bus.IF_ID_uses_rs2 && (ex_q.rd == bus.IF_ID_rs2);
        load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0)
                   && bus.IF_ID_valid && (rs1_hit || rs2_hit);
    end

    // Front-end freeze only when the bubble will actually be inserted this edge.
    assign bus.stall = load_use && !bus.flush && !bus.hold;

    // Slot captured from decode; side-effecting controls are masked for an invalid slot.
    always_comb begin
        capture.valid      = bus.IF_ID_valid;
        capture.pc         = bus.IF_ID_pc;
        capture.rd1        = bus.IF_ID_rd1;
        capture.rd2        = bus.IF_ID_rd2;
        capture.imm        = bus.IF_ID_imm;
        capture.rs1        = bus.IF_ID_rs1;
        capture.rs2        = bus.IF_ID_rs2;
        capture.rd         = bus.IF_ID_rd;
        capture.reg_write  = bus.IF_ID_RegWrite && bus.IF_ID_valid;
        capture.mem_read   = bus.IF_ID_MemRead  && bus.IF_ID_valid;
        capture.mem_write  = bus.IF_ID_MemWrite && bus.IF_ID_valid;
        capture.mem_to_reg = bus.IF_ID_MemtoReg;
        capture.alu_src    = bus.IF_ID_ALUSrc;
        capture.branch     = bus.IF_ID_Branch   && bus.IF_ID_valid;
        capture.alu_op     = bus.IF_ID_ALUOp;
        capture.funct3     = bus.IF_ID_funct3;
        capture.funct7_5   = bus.IF_ID_funct7_5;
    end

    // Register update, priority flush > hold > load-use bubble > capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q <= '0;
        end else if (bus.flush) begin
            ex_q <= '0;
        end else if (bus.hold) begin
            ex_q <= ex_q;
        end else if (load_use) begin
            ex_q <= '0;
        end else begin
            ex_q <= capture;
        end
    end

    // Saturating count of load-use bubbles only; flush bubbles and held cycles are not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_q <= '0;
        end else if (!bus.flush && !bus.hold && load_use && (bubble_q != CNT_MAX)) begin
            bubble_q <= bubble_q + CNT_ONE;
        end
    end

    assign bus.bubble_count   = bubble_q;
    assign bus.ID_EX_valid    = ex_q.valid;
    assign bus.ID_EX_pc       = ex_q.pc;
    assign bus.ID_EX_rd1      = ex_q.rd1;
    assign bus.ID_EX_rd2      = ex_q.rd2;
    assign bus.ID_EX_imm      = ex_q.imm;
    assign bus.ID_EX_rs1      = ex_q.rs1;
    assign bus.ID_EX_rs2      = ex_q.rs2;
    assign bus.ID_EX_rd       = ex_q.rd;
    assign bus.ID_EX_RegWrite = ex_q.reg_write;
    assign bus.ID_EX_MemRead  = ex_q.mem_read;
    assign bus.ID_EX_MemWrite = ex_q.mem_write;
    assign bus.ID_EX_MemtoReg = ex_q.mem_to_reg;
    assign bus.ID_EX_ALUSrc   = ex_q.alu_src;
    assign bus.ID_EX_Branch   = ex_q.branch;
    assign bus.ID_EX_ALUOp    = ex_q.alu_op;
    assign bus.ID_EX_funct3   = ex_q.funct3;
    assign bus.ID_EX_funct7_5 = ex_q.funct7_5;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - table-driven scoreboard bench for id_ex_stage
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        alusrc;
        logic        branch;
        logic [1:0]  aluop;
        logic [2:0]  funct3;
        logic        funct7_5;
    } ex_t;

    typedef struct {
        ex_t        ins;
        logic       u1;
        logic       u2;
        logic       flush;
        logic       hold;
        logic       exp_stall;
        logic [1:0] exp_cnt;
    } vec_t;

    typedef struct packed {
        ex_t        ex;
        logic [1:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    ex_t        mdl;
    logic [1:0] mcnt;
    exp_t       sb[$];
    vec_t       tbl[23];

    id_ex_stage_if #(.XLEN(32), .CNTW(2)) bus ();

    id_ex_stage #(.XLEN(32), .CNTW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic ex_t read_dut();
        ex_t r;
        r.valid    = bus.ID_EX_valid;
        r.pc       = bus.ID_EX_pc;
        r.rd1      = bus.ID_EX_rd1;
        r.rd2      = bus.ID_EX_rd2;
        r.imm      = bus.ID_EX_imm;
        r.rs1      = bus.ID_EX_rs1;
        r.rs2      = bus.ID_EX_rs2;
        r.rd       = bus.ID_EX_rd;
        r.regwrite = bus.ID_EX_RegWrite;
        r.memread  = bus.ID_EX_MemRead;
        r.memwrite = bus.ID_EX_MemWrite;
        r.memtoreg = bus.ID_EX_MemtoReg;
        r.alusrc   = bus.ID_EX_ALUSrc;
        r.branch   = bus.ID_EX_Branch;
        r.aluop    = bus.ID_EX_ALUOp;
        r.funct3   = bus.ID_EX_funct3;
        r.funct7_5 = bus.ID_EX_funct7_5;
        return r;
    endfunction

    function automatic vec_t mk(input logic valid, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                input logic memread, input logic flush, input logic hold,
                                input logic es, input logic [1:0] ec);
        vec_t v;
        v.ins.valid    = valid;
        v.ins.pc       = $urandom;
        v.ins.rd1      = $urandom;
        v.ins.rd2      = $urandom;
        v.ins.imm      = $urandom;
        v.ins.rs1      = rs1;
        v.ins.rs2      = rs2;
        v.ins.rd       = rd;
        v.ins.regwrite = 1'b1;
        v.ins.memread  = memread;
        v.ins.memwrite = 1'($urandom_range(0, 1));
        v.ins.memtoreg = memread;
        v.ins.alusrc   = 1'($urandom_range(0, 1));
        v.ins.branch   = 1'($urandom_range(0, 1));
        v.ins.aluop    = 2'($urandom_range(0, 3));
        v.ins.funct3   = 3'($urandom_range(0, 7));
        v.ins.funct7_5 = 1'($urandom_range(0, 1));
        v.u1 = u1; v.u2 = u2; v.flush = flush; v.hold = hold;
        v.exp_stall = es; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.IF_ID_valid    = v.ins.valid;
        bus.IF_ID_pc       = v.ins.pc;
        bus.IF_ID_rd1      = v.ins.rd1;
        bus.IF_ID_rd2      = v.ins.rd2;
        bus.IF_ID_imm      = v.ins.imm;
        bus.IF_ID_rs1      = v.ins.rs1;
        bus.IF_ID_rs2      = v.ins.rs2;
        bus.IF_ID_rd       = v.ins.rd;
        bus.IF_ID_uses_rs1 = v.u1;
        bus.IF_ID_uses_rs2 = v.u2;
        bus.IF_ID_RegWrite = v.ins.regwrite;
        bus.IF_ID_MemRead  = v.ins.memread;
        bus.IF_ID_MemWrite = v.ins.memwrite;
        bus.IF_ID_MemtoReg = v.ins.memtoreg;
        bus.IF_ID_ALUSrc   = v.ins.alusrc;
        bus.IF_ID_Branch   = v.ins.branch;
        bus.IF_ID_ALUOp    = v.ins.aluop;
        bus.IF_ID_funct3   = v.ins.funct3;
        bus.IF_ID_funct7_5 = v.ins.funct7_5;
        bus.flush          = v.flush;
        bus.hold           = v.hold;
    endtask

    // Reference model of one clock edge; pushes the expected EX slot and count.
    task automatic model_edge(input vec_t v);
        logic lu;
        ex_t  c;
        lu = mdl.valid && mdl.memread && (mdl.rd != 5'd0) && v.ins.valid &&
             ((v.u1 && mdl.rd == v.ins.rs1) || (v.u2 && mdl.rd == v.ins.rs2));
        c = v.ins;
        if (!v.ins.valid) begin
            c.regwrite = 1'b0; c.memread = 1'b0; c.memwrite = 1'b0; c.branch = 1'b0;
        end
        if (v.flush)      mdl = '0;
        else if (v.hold)  mdl = mdl;
        else if (lu) begin
            mdl = '0;
            if (mcnt != 2'd3) mcnt = mcnt + 2'd1;
        end else          mdl = c;
        sb.push_back({mdl, mcnt});
    endtask

    task automatic step(input vec_t v, input string nm);
        exp_t e;
        drive(v);
        #2;
        check({nm, " stall"}, 192'(bus.stall), 192'(v.exp_stall));
        model_edge(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s scoreboard: got empty expected entry", nm);
        end else begin
            e = sb.pop_front();
            check({nm, " regs"}, 192'(read_dut()), 192'(e.ex));
            check({nm, " count"}, 192'(bus.bubble_count), 192'(e.cnt));
            check({nm, " table_count"}, 192'(bus.bubble_count), 192'(v.exp_cnt));
        end
    endtask

    initial begin
        vec_t z;
        vec_t dep;
        n_cmp = 0; n_bad = 0;
        mdl = '0; mcnt = 2'd0;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        z.ins = '0;
        reset = 1'b1;
        drive(z);
        #1;
        check("reset_async regs", 192'(read_dut()), 192'(0));
        check("reset_async count", 192'(bus.bubble_count), 192'(0));
        check("reset_async stall", 192'(bus.stall), 192'(0));
        #21;
        reset = 1'b0;
        #1;
        check("reset_release stall", 192'(bus.stall), 192'(0));
        @(posedge clk);
        #1;

        tbl[0]  = mk(1, 1, 1, 2, 1, 5, 0, 0, 0, 0, 0);
        tbl[0].ins.rd1 = 32'h1234;
        tbl[1]  = mk(1, 2, 1, 3, 0, 7, 1, 0, 0, 0, 0);
        tbl[2]  = mk(1, 7, 1, 1, 1, 8, 0, 0, 0, 1, 1);
        tbl[3]  = tbl[2]; tbl[3].exp_stall = 1'b0;
        tbl[4]  = mk(1, 3, 1, 0, 0, 7, 1, 0, 0, 0, 1);
        tbl[5]  = mk(1, 9, 1, 7, 0, 0, 1, 0, 0, 0, 1);
        tbl[6]  = mk(1, 0, 1, 0, 1, 7, 1, 0, 0, 0, 1);
        tbl[7]  = mk(1, 4, 0, 7, 1, 9, 0, 1, 1, 0, 1);
        tbl[8]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1);
        tbl[9]  = mk(1, 7, 1, 5, 0, 10, 0, 0, 1, 0, 1);
        tbl[10] = mk(1, 7, 1, 5, 0, 10, 0, 0, 1, 0, 1);
        tbl[11] = mk(1, 7, 1, 5, 0, 10, 0, 0, 1, 0, 1);
        tbl[12] = mk(1, 7, 1, 5, 0, 10, 0, 0, 0, 1, 2);
        tbl[13] = tbl[12]; tbl[13].exp_stall = 1'b0;
        tbl[14] = mk(0, 10, 1, 10, 1, 11, 1, 0, 0, 0, 2);
        tbl[14].ins.regwrite = 1'b1; tbl[14].ins.memwrite = 1'b1; tbl[14].ins.branch = 1'b1;
        tbl[15] = mk(1, 11, 1, 0, 0, 12, 1, 0, 0, 0, 2);
        tbl[16] = mk(1, 0, 0, 12, 1, 13, 1, 0, 0, 1, 3);
        tbl[17] = tbl[16]; tbl[17].exp_stall = 1'b0;
        tbl[18] = mk(1, 13, 1, 0, 0, 14, 1, 0, 0, 1, 3);
        tbl[19] = tbl[18]; tbl[19].exp_stall = 1'b0;
        tbl[20] = mk(1, 14, 1, 0, 0, 15, 0, 0, 0, 1, 3);
        tbl[21] = tbl[20]; tbl[21].exp_stall = 1'b0;
        tbl[22] = mk(1, 1, 1, 2, 1, 15, 1, 0, 0, 0, 3);

        for (int i = 0; i < 23; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset asserted mid-stall discards everything, asynchronously.
        dep = mk(1, 15, 1, 0, 0, 16, 0, 0, 0, 1, 3);
        drive(dep);
        #2;
        check("pre_reset stall", 192'(bus.stall), 192'(1));
        #2;
        reset = 1'b1;
        #1;
        check("mid_reset regs", 192'(read_dut()), 192'(0));
        check("mid_reset count", 192'(bus.bubble_count), 192'(0));
        check("mid_reset stall", 192'(bus.stall), 192'(0));
        mdl = '0; mcnt = 2'd0;
        @(posedge clk);
        #1;
        check("reset_edge regs", 192'(read_dut()), 192'(0));
        #3;
        reset = 1'b0;
        #1;
        check("post_reset stall", 192'(bus.stall), 192'(0));
        dep.exp_stall = 1'b0;
        dep.exp_cnt = 2'd0;
        step(dep, "post_reset_capture");
        step(mk(1, 16, 1, 0, 0, 17, 0, 0, 0, 0, 0), "post_reset_next");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
